// File: rtl/muldiv_seq_if.sv
// Bundle between the EX stage and the multiply/divide sequencer.
// Signals:
//   start/op/in1/in2  launch request with opcode and the rs/rt operands
//   flush             abort the operation in flight
//   hi_we/lo_we/wdata MTHI/MTLO writes
//   busy/done         operation in flight / result written this cycle
//   hi/lo             architectural HI/LO registers
// Modports: master drives requests (EX stage), slave is the sequencer.
interface muldiv_seq_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] in1;
  logic [XLEN-1:0] in2;
  logic            flush;
  logic            hi_we;
  logic            lo_we;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;

  modport master (
    output start, op, in1, in2, flush, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, in1, in2, flush, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
// One bit per cycle through a single (XLEN+1)-bit adder/subtractor,
// operating on magnitudes with a final sign-fix cycle.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    muldiv_seq_if slave: start/op/in1/in2/flush/hi_we/lo_we/wdata in,
//          busy/done/hi/lo out (all outputs straight from registers)
// op encoding: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
module muldiv_seq #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // r_a: multiplicand or divisor; r_hw/r_lw: {acc,mplr} or {rem,quo}
  logic [1:0]      r_state,  w_state_nxt;
  logic [1:0]      r_op,     w_op_nxt;
  logic [XLEN-1:0] r_a,      w_a_nxt;
  logic [XLEN-1:0] r_hw,     w_hw_nxt;
  logic [XLEN-1:0] r_lw,     w_lw_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
  logic            r_neg_q,  w_neg_q_nxt;
  logic            r_neg_r,  w_neg_r_nxt;
  logic            r_dz,     w_dz_nxt;
  logic [XLEN-1:0] r_hi,     w_hi_nxt;
  logic [XLEN-1:0] r_lo,     w_lo_nxt;
  logic            r_busy,   w_busy_nxt;
  logic            r_done,   w_done_nxt;

  // Operand conditioning: signed ops run on magnitudes
  logic            w_signed;
  logic            w_neg1;
  logic            w_neg2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;

  assign w_signed = ~bus.op[0];
  assign w_neg1   = w_signed & bus.in1[XLEN-1];
  assign w_neg2   = w_signed & bus.in2[XLEN-1];
  assign w_abs1   = w_neg1 ? -bus.in1 : bus.in1;
  assign w_abs2   = w_neg2 ? -bus.in2 : bus.in2;

  // Shift-add step: carry out of the add becomes the new acc MSB
  logic [XLEN:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_hw} + (r_lw[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});

  // Restoring divide step: trial sign bit decides keep/restore
  logic [XLEN:0] w_rem_sh;
  logic [XLEN:0] w_trial;
  logic          w_fits;
  assign w_rem_sh = {r_hw, r_lw[XLEN-1]};
  assign w_trial  = w_rem_sh - {1'b0, r_a};
  assign w_fits   = ~w_trial[XLEN];

  // Sign fix; a zero divisor leaves the all-ones quotient un-negated
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  assign w_prod     = {r_hw, r_lw};
  assign w_prod_fix = r_neg_q ? -w_prod : w_prod;
  assign w_quo_fix  = (r_neg_q & ~r_dz) ? -r_lw : r_lw;
  assign w_rem_fix  = r_neg_r ? -r_hw : r_hw;

  // Next-state and datapath control
  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_a_nxt     = r_a;
    w_hw_nxt    = r_hw;
    w_lw_nxt    = r_lw;
    w_cnt_nxt   = r_cnt;
    w_neg_q_nxt = r_neg_q;
    w_neg_r_nxt = r_neg_r;
    w_dz_nxt    = r_dz;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        // start takes priority; a same-cycle MTHI/MTLO is dropped
        if (bus.start) begin
          w_state_nxt = S_ITER;
          w_op_nxt    = bus.op;
          w_a_nxt     = bus.op[1] ? w_abs2 : w_abs1;
          w_hw_nxt    = '0;
          w_lw_nxt    = bus.op[1] ? w_abs1 : w_abs2;
          w_neg_q_nxt = w_neg1 ^ w_neg2;
          w_neg_r_nxt = w_neg1;
          w_dz_nxt    = (bus.in2 == '0);
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end else begin
          if (bus.hi_we) w_hi_nxt = bus.wdata;
          if (bus.lo_we) w_lo_nxt = bus.wdata;
        end
      end

      S_ITER: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end else begin
          if (r_op[1]) begin
            w_hw_nxt = w_fits ? w_trial[XLEN-1:0] : w_rem_sh[XLEN-1:0];
            w_lw_nxt = {r_lw[XLEN-2:0], w_fits};
          end else begin
            w_hw_nxt = w_mul_sum[XLEN:1];
            w_lw_nxt = {w_mul_sum[0], r_lw[XLEN-1:1]};
          end
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) w_state_nxt = S_FIX;
        end
      end

      S_FIX: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        if (!bus.flush) begin
          if (r_op[1]) begin
            w_hi_nxt = w_rem_fix;
            w_lo_nxt = w_quo_fix;
          end else begin
            w_hi_nxt = w_prod_fix[2*XLEN-1:XLEN];
            w_lo_nxt = w_prod_fix[XLEN-1:0];
          end
          w_done_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_op    <= '0;
      r_a     <= '0;
      r_hw    <= '0;
      r_lw    <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_a     <= w_a_nxt;
      r_hw    <= w_hw_nxt;
      r_lw    <= w_lw_nxt;
      r_cnt   <= w_cnt_nxt;
      r_neg_q <= w_neg_q_nxt;
      r_neg_r <= w_neg_r_nxt;
      r_dz    <= w_dz_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
